// File: rtl/cpu8_core.sv
// 8-bit accumulator CPU: 16x8 instruction ROM, 16x8 data RAM, Z/C flags.
// Each instruction takes three clocks: FETCH, DECODE, EXECUTE.
module cpu8_core (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] pc_o,
  output logic [7:0] acc_o,
  output logic       zf_o,
  output logic       cf_o,
  output logic [7:0] out_o,
  output logic       out_vld_o,
  output logic       halted_o
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Power-up program image; reset leaves it untouched so it can be reloaded externally.
  logic [7:0] r_rom [16] = '{8'h15, 8'h63, 8'hE0, 8'h32, 8'h71, 8'hC7, 8'hB4, 8'hE0,
                             8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] r_ram [16];

  logic [1:0] r_state;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_acc;
  logic [7:0] r_out;
  logic       r_zf;
  logic       r_cf;
  logic       r_out_vld;
  logic       r_halted;

  logic [3:0] w_op;
  logic [3:0] w_imm;
  logic [7:0] w_operand;
  logic [8:0] w_alu;
  logic       w_acc_wr;
  logic       w_cf_wr;

  // Bit 8 carries the ADD carry-out or the SUB borrow (set when a < b).
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] r;
    case (op)
      OP_LDI, OP_LDA:  r = {1'b0, b};
      OP_ADD, OP_ADDI: r = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_SUBI: r = {1'b0, a} - {1'b0, b};
      OP_AND:          r = {1'b0, a & b};
      OP_OR:           r = {1'b0, a | b};
      OP_XOR:          r = {1'b0, a ^ b};
      default:         r = {1'b0, a};
    endcase
    return r;
  endfunction

  assign w_op      = r_ir[7:4];
  assign w_imm     = r_ir[3:0];
  assign w_operand = (w_op inside {OP_LDI, OP_ADDI, OP_SUBI}) ? {4'h0, w_imm} : r_ram[w_imm];
  assign w_alu     = alu_f(w_op, r_acc, w_operand);
  assign w_acc_wr  = w_op inside {OP_LDI, OP_LDA, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI,
                                  OP_AND, OP_OR, OP_XOR};
  assign w_cf_wr   = w_op inside {OP_ADD, OP_SUB, OP_ADDI, OP_SUBI};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= 4'h0;
      r_ir      <= 8'h00;
      r_acc     <= 8'h00;
      r_out     <= 8'h00;
      r_zf      <= 1'b0;
      r_cf      <= 1'b0;
      r_out_vld <= 1'b0;
      r_halted  <= 1'b0;
      for (int i = 0; i < 16; i++) r_ram[i] <= 8'h00;
    end else begin
      r_out_vld <= 1'b0;
      if (!r_halted) begin
        case (r_state)
          S_FETCH: begin
            r_ir    <= r_rom[r_pc];
            r_pc    <= r_pc + 4'd1;
            r_state <= S_DECODE;
          end
          S_DECODE: r_state <= S_EXEC;
          S_EXEC: begin
            r_state <= S_FETCH;
            case (w_op)
              OP_STA: r_ram[w_imm] <= r_acc;
              OP_JMP: r_pc <= w_imm;
              OP_JZ:  if (r_zf) r_pc <= w_imm;
              OP_JC:  if (r_cf) r_pc <= w_imm;
              OP_OUT: begin
                r_out     <= r_acc;
                r_out_vld <= 1'b1;
              end
              OP_HLT: r_halted <= 1'b1;
              default: ;
            endcase
            if (w_acc_wr) begin
              r_acc <= w_alu[7:0];
              r_zf  <= (w_alu[7:0] == 8'h00);
            end
            if (w_cf_wr) r_cf <= w_alu[8];
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign pc_o      = r_pc;
  assign acc_o     = r_acc;
  assign zf_o      = r_zf;
  assign cf_o      = r_cf;
  assign out_o     = r_out;
  assign out_vld_o = r_out_vld;
  assign halted_o  = r_halted;

endmodule

// File: tb/tb_cpu8_core.sv
// Directed bench for cpu8_core: architectural checks at fixed edges plus a
// queue of expected OUT values consumed whenever out_vld_o pulses.
module tb_cpu8_core;

  logic       clk;
  logic       rst;
  logic [3:0] pc_o;
  logic [7:0] acc_o;
  logic       zf_o;
  logic       cf_o;
  logic [7:0] out_o;
  logic       out_vld_o;
  logic       halted_o;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  cpu8_core dut (
    .clk       (clk),
    .rst       (rst),
    .pc_o      (pc_o),
    .acc_o     (acc_o),
    .zf_o      (zf_o),
    .cf_o      (cf_o),
    .out_o     (out_o),
    .out_vld_o (out_vld_o),
    .halted_o  (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    check("rst_pc", pc_o, 8'h0);
    check("rst_acc", acc_o, 8'h00);
    check("rst_zf", zf_o, 8'h0);
    check("rst_cf", cf_o, 8'h0);
    check("rst_out", out_o, 8'h00);
    check("rst_vld", out_vld_o, 8'h0);
    check("rst_halt", halted_o, 8'h0);
  endtask

  task automatic load_rom(input logic [7:0] img[16]);
    for (int i = 0; i < 16; i++) dut.r_rom[i] = img[i];
  endtask

  // Scoreboard: every OUT pulse must match the next queued value.
  always @(negedge clk) begin
    if (out_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", out_vld_o, 8'h0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("out_sb", out_o, e);
      end
    end
  end

  initial begin
    logic [7:0] prog_cb[16];
    logic [7:0] prog_nop[16];
    prog_cb = '{8'h1F, 8'h30, 8'h40, 8'h7F, 8'h71, 8'h7F, 8'hDA, 8'hE0,
                8'hF0, 8'hF0, 8'h6F, 8'hA0, 8'hCF, 8'hE0, 8'hF0, 8'h00};
    for (int i = 0; i < 16; i++) prog_nop[i] = 8'h00;
    rst = 1'b1;

    // Default program, full run
    do_reset();
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    rst = 1'b0;
    step(3);
    check("e3_acc", acc_o, 8'h05);
    check("e3_pc", pc_o, 8'h1);
    step(3);
    check("e6_acc", acc_o, 8'h08);
    check("e6_cf", cf_o, 8'h0);
    check("e6_zf", zf_o, 8'h0);
    step(3);
    check("e9_out", out_o, 8'h08);
    check("e9_vld", out_vld_o, 8'h1);
    check("e9_pc", pc_o, 8'h3);
    step(1);
    check("e10_vld", out_vld_o, 8'h0);
    step(74);
    check("e84_out", out_o, 8'h00);
    check("e84_vld", out_vld_o, 8'h1);
    step(3);
    check("e87_halt", halted_o, 8'h1);
    check("e87_acc", acc_o, 8'h00);
    check("e87_zf", zf_o, 8'h1);
    check("e87_cf", cf_o, 8'h0);
    check("e87_pc", pc_o, 8'h9);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("frz_pc", pc_o, 8'h9);
      check("frz_halt", halted_o, 8'h1);
      check("frz_vld", out_vld_o, 8'h0);
    end
    check("q_empty_default", 8'(exp_q.size()), 8'h0);

    // Mid-run reset during ADDI
    do_reset();
    check("rst_ram2", dut.r_ram[2], 8'h00);
    rst = 1'b0;
    step(3);
    check("mr_acc_pre", acc_o, 8'h05);
    step(1);
    rst = 1'b1;
    step(1);
    check("mr_pc", pc_o, 8'h0);
    check("mr_acc", acc_o, 8'h00);
    rst = 1'b0;
    step(3);
    check("mr_acc_restart", acc_o, 8'h05);
    check("mr_pc_restart", pc_o, 8'h1);

    // Carry / borrow / JC program
    rst = 1'b1;
    load_rom(prog_cb);
    do_reset();
    exp_q.push_back(8'h01);
    rst = 1'b0;
    step(9);
    check("cb_add_acc", acc_o, 8'h1E);
    check("cb_add_cf", cf_o, 8'h0);
    check("cb_add_zf", zf_o, 8'h0);
    step(3);
    check("cb_subi_acc", acc_o, 8'h0F);
    step(3);
    check("cb_subi1_acc", acc_o, 8'h0E);
    step(3);
    check("cb_borrow_acc", acc_o, 8'hFF);
    check("cb_borrow_cf", cf_o, 8'h1);
    check("cb_borrow_zf", zf_o, 8'h0);
    step(3);
    check("cb_jc_pc", pc_o, 8'hA);
    step(3);
    check("cb_addi_acc", acc_o, 8'h0E);
    check("cb_addi_cf", cf_o, 8'h1);
    check("cb_addi_pc", pc_o, 8'hB);
    step(3);
    check("cb_xor_acc", acc_o, 8'h01);
    check("cb_xor_cf", cf_o, 8'h1);
    step(3);
    check("cb_jz_nt_pc", pc_o, 8'hD);
    step(3);
    check("cb_out", out_o, 8'h01);
    check("cb_vld", out_vld_o, 8'h1);
    step(3);
    check("cb_halt", halted_o, 8'h1);
    check("cb_pc", pc_o, 8'hF);
    check("q_empty_cb", 8'(exp_q.size()), 8'h0);

    // All-NOP ROM: PC wraps, never halts
    rst = 1'b1;
    load_rom(prog_nop);
    do_reset();
    rst = 1'b0;
    step(45);
    check("wrap_pc15", pc_o, 8'hF);
    step(3);
    check("wrap_pc0", pc_o, 8'h0);
    check("wrap_halt", halted_o, 8'h0);
    check("wrap_acc", acc_o, 8'h00);
    check("q_empty_nop", 8'(exp_q.size()), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
